ntt_bf_sched: RTL
=================

# ntt_bf_sched

Schedules one complete NTT or INTT transform over a coefficient memory of N words, issuing one butterfly per cycle to the add_sub/multiplier butterfly pipeline. For every butterfly it generates the read address pair, the twiddle-table index and the delayed write-back address pair. It enforces the inter-stage data dependency by draining the pipeline between stages. It presents a start/busy/done handshake to the polynomial-level control.

## Interface
- isNTT, 1: 1 selects the forward NTT (Cooley-Tukey, len halves each stage); 0 selects the INTT (Gentleman-Sande, len doubles each stage).
- LOG_N, 8: log2 of the coefficient count N; the transform has LOG_N stages.
- BF_LAT, 4: butterfly pipeline latency in cycles, from read issue to write-back; legal range is ≥1.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a transform; sampled only in IDLE.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the transform completes.
- rd_en  out  1  a butterfly read is issued this cycle.
- rd_addr0, rd_addr1  out  LOG_N each  butterfly operand addresses.
- tw_idx  out  LOG_N  twiddle-table index, valid with rd_en; table depth is N and index 0 is unused.
- wr_en  out  1  butterfly results are written this cycle.
- wr_addr0, wr_addr1  out  LOG_N each  write-back addresses (in-place).
- stage  out  $clog2(LOG_N)  current stage number s.

## Operation
- Reset: all outputs are 0, the FSM is in IDLE, counters s=0 and j=0, and the write-delay line holds no valid entries.
- FSM states are IDLE, RUN and DRAIN.
  - IDLE: start=1 moves to RUN with s=0, j=0.
  - RUN: rd_en=1 and j increments every cycle. When j=N/2-1, j wraps to 0 and the FSM goes to DRAIN.
  - DRAIN: rd_en=0 and a drain counter runs for BF_LAT cycles. Afterwards, if s<LOG_N-1, s increments and the FSM returns to RUN. Otherwise it goes to IDLE and pulses done.
- Address generation for butterfly j in stage s:
  - len = N>>(s+1) when isNTT, and len = 1<<s otherwise.
  - group = j / len and k = j % len. Compute these with shift and mask, not a divider.
  - rd_addr0 = 2·len·group + k and rd_addr1 = rd_addr0 + len.
  - NTT: tw_idx = (1<<s) + group.
  - INTT: tw_idx = (N>>s) − 1 − group.
- Write-back uses a BF_LAT-deep shift register of {valid, addr0, addr1}. wr_en and wr_addr0/1 equal the rd_en and rd_addr0/1 issued exactly BF_LAT cycles earlier.
- start while busy is ignored.
- start in the cycle done is high (the first IDLE cycle) is accepted, so transforms run back-to-back.
- Reset asserted mid-transform clears everything immediately. No further wr_en is produced, and any pending writes are discarded.
- All address arithmetic is unsigned LOG_N-bit. By construction no result exceeds N−1.

## Timing
- Call the start-sampling edge cycle 0. The first rd_en is in cycle 1.
- Each stage takes N/2 RUN cycles plus BF_LAT DRAIN cycles.
- The last read of a stage in cycle T is written in cycle T+BF_LAT. The next stage's first read is in cycle T+BF_LAT+1, so memory write-before-read is never required.
- The final wr_en is in the last DRAIN cycle. done is high in the following cycle, which is cycle LOG_N·(N/2+BF_LAT)+1, with busy=0.
- busy rises in cycle 1 and falls in the done cycle.
- stage changes on the DRAIN→RUN edge.

## Test plan
- Reset and idle:
  - Stimulus: reset, then start=0 for 100 cycles.
  - Required: all outputs stay 0.
- NTT address sequence, LOG_N=8, BF_LAT=4, start pulse:
  - cycle 1: rd 0/128, tw 1.
  - cycle 128: rd 127/255, tw 1.
  - stage 1, j=64: rd 128/192, tw 3.
  - stage 7, j=5: rd 10/11, tw 133.
  - done in cycle 1057.
  - Every address pair across the transform is written exactly once per stage.
- INTT (isNTT=0):
  - stage 0, j=0: rd 0/1, tw 255.
  - stage 7, j=0: rd 0/128, tw 1.
  - Each stage covers all N addresses exactly once.
- Write alignment and drain, BF_LAT=1 and BF_LAT=7:
  - wr_en and wr_addr match the reads delayed by BF_LAT.
  - rd_en is low for exactly BF_LAT cycles between stages.
  - No read of stage s+1 occurs before the last write of stage s.
- Handshake edge cases:
  - start held high throughout: the transform is not restarted while busy, and the next transform starts in the done cycle so that rd_en rises in the cycle after done.
  - start pulse mid-RUN: ignored.
- Asynchronous reset mid-RUN of stage 3:
  - All outputs are 0 immediately after rst_n falls, and no wr_en appears afterwards.
  - A new start after release runs the full 1056+1 cycle sequence from stage 0.

Source files
------------

// File: rtl/ntt_bf_sched.sv
// ntt_bf_sched: butterfly scheduler for one in-place NTT/INTT transform.
// It issues one read pair and one twiddle index per cycle, then drains the
// butterfly pipeline before each following stage. Write-back addresses are
// the issued reads delayed by BF_LAT cycles.
module ntt_bf_sched #(
    parameter bit          isNTT  = 1'b1,
    parameter int unsigned LOG_N  = 8,
    parameter int unsigned BF_LAT = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       rd_en,
    output logic [LOG_N-1:0]           rd_addr0,
    output logic [LOG_N-1:0]           rd_addr1,
    output logic [LOG_N-1:0]           tw_idx,
    output logic                       wr_en,
    output logic [LOG_N-1:0]           wr_addr0,
    output logic [LOG_N-1:0]           wr_addr1,
    output logic [$clog2(LOG_N)-1:0]   stage
);

    localparam int unsigned AW   = LOG_N;
    localparam int unsigned N    = 1 << LOG_N;
    localparam int unsigned HALF = N / 2;
    localparam int unsigned JW   = (AW > 1) ? AW - 1 : 1;
    localparam int unsigned SW   = (LOG_N > 1) ? $clog2(LOG_N) : 1;
    localparam int unsigned DW   = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [JW-1:0]   j_q, j_d;
    logic [DW-1:0]   d_q, d_d;
    logic            done_d;

    logic [SW-1:0]   lg;
    logic [AW-1:0]   jw, len, grp, kk, a0, a1, tw;
    logic [AW:0]     nsh;

    logic            vld_q [BF_LAT];
    logic [AW-1:0]   wa0_q [BF_LAT];
    logic [AW-1:0]   wa1_q [BF_LAT];

    // Next-state logic: stage/butterfly/drain counters and the done pulse.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        d_d     = d_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    s_d     = '0;
                    j_d     = '0;
                end
            end
            RUN: begin
                if (j_q == JW'(HALF - 1)) begin
                    j_d     = '0;
                    d_d     = '0;
                    state_d = DRAIN;
                end else begin
                    j_d = j_q + JW'(1);
                end
            end
            DRAIN: begin
                if (d_q == DW'(BF_LAT - 1)) begin
                    if (s_q == SW'(LOG_N - 1)) begin
                        state_d = IDLE;
                        s_d     = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        s_d     = s_q + SW'(1);
                    end
                end else begin
                    d_d = d_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address/twiddle for the butterfly about to be issued (shift and mask only).
    always_comb begin
        lg  = isNTT ? (SW'(LOG_N - 1) - s_d) : s_d;
        jw  = AW'(j_d);
        len = AW'(1) << lg;
        grp = jw >> lg;
        kk  = jw & (len - AW'(1));
        a0  = ((grp << lg) << 1) | kk;
        a1  = a0 + len;
        nsh = (AW + 1)'(N) >> s_d;
        if (isNTT) begin
            tw = (AW'(1) << s_d) + grp;
        end else begin
            tw = AW'(nsh - (AW + 1)'(1)) - grp;
        end
    end

    // State, counters and registered read-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s_q      <= '0;
            j_q      <= '0;
            d_q      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr0 <= '0;
            rd_addr1 <= '0;
            tw_idx   <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            j_q      <= j_d;
            d_q      <= d_d;
            busy     <= (state_d != IDLE);
            done     <= done_d;
            rd_en    <= (state_d == RUN);
            rd_addr0 <= (state_d == RUN) ? a0 : '0;
            rd_addr1 <= (state_d == RUN) ? a1 : '0;
            tw_idx   <= (state_d == RUN) ? tw : '0;
        end
    end

    assign stage = s_q;

    // Write-back delay line: reads reappear as writes BF_LAT cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BF_LAT; i++) begin
                vld_q[i] <= 1'b0;
                wa0_q[i] <= '0;
                wa1_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_en;
            wa0_q[0] <= rd_addr0;
            wa1_q[0] <= rd_addr1;
            for (int unsigned i = 1; i < BF_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                wa0_q[i] <= wa0_q[i-1];
                wa1_q[i] <= wa1_q[i-1];
            end
        end
    end

    assign wr_en    = vld_q[BF_LAT-1];
    assign wr_addr0 = wa0_q[BF_LAT-1];
    assign wr_addr1 = wa1_q[BF_LAT-1];

endmodule
